// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for the shared memory port: fetch requester, load/store requester,
// and the external memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  im_req;
  logic [ADDR_W-1:0]     im_addr;
  logic                  im_done;
  logic [DATA_W-1:0]     im_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_wstrb;
  logic                  dm_done;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  stallreq_if;
  logic                  stallreq_mem;

  // Arbiter view.
  modport slave (
    input  im_req, im_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  mem_ack, mem_rdata,
    output im_done, im_rdata, dm_done, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output stallreq_if, stallreq_mem
  );

  // Environment view: requesters plus the memory device.
  modport master (
    output im_req, im_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output mem_ack, mem_rdata,
    input  im_done, im_rdata, dm_done, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch and load/store; DM has priority,
// bounded by a starvation counter so fetch always makes progress.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_DM_RUN = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int RUN_W = $clog2(MAX_DM_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

  typedef enum logic [1:0] {
    IDLE,
    IM_BUSY,
    DM_BUSY
  } state_t;

  state_t                state_q;
  logic [RUN_W-1:0]      dm_run_q, dm_run_d;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic [DATA_W/8-1:0]   mem_wstrb_q;

  logic dm_wins;
  logic grant_dm;
  logic grant_im;
  logic im_done;
  logic dm_done;

  always_comb begin
    dm_wins  = bus.dm_req && !(bus.im_req && (dm_run_q == RUN_MAX));
    grant_dm = (state_q == IDLE) && dm_wins;
    grant_im = (state_q == IDLE) && !dm_wins && bus.im_req;
  end

  // Run length counts only DM grants that actually made IM wait.
  always_comb begin
    dm_run_d = dm_run_q;
    if (grant_dm) begin
      if (!bus.im_req) begin
        dm_run_d = '0;
      end else if (dm_run_q != RUN_MAX) begin
        dm_run_d = dm_run_q + RUN_W'(1);
      end
    end else if (grant_im) begin
      dm_run_d = '0;
    end
  end

  // Launch registers drive mem_* directly and are cleared on return to IDLE,
  // so the port reads all-zero whenever no transaction is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dm_run_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      dm_run_q <= dm_run_d;
      case (state_q)
        IDLE: begin
          if (grant_dm) begin
            state_q     <= DM_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            mem_wstrb_q <= bus.dm_wstrb;
          end else if (grant_im) begin
            state_q     <= IM_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.im_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end
        end
        IM_BUSY, DM_BUSY: begin
          if (bus.mem_ack) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    im_done = (state_q == IM_BUSY) && bus.mem_ack;
    dm_done = (state_q == DM_BUSY) && bus.mem_ack;
  end

  assign bus.im_done      = im_done;
  assign bus.dm_done      = dm_done;
  assign bus.im_rdata     = im_done ? bus.mem_rdata : '0;
  assign bus.dm_rdata     = dm_done ? bus.mem_rdata : '0;

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_wstrb    = mem_wstrb_q;

  assign bus.stallreq_if  = bus.im_req && !im_done;
  assign bus.stallreq_mem = bus.dm_req && !dm_done;

endmodule
